// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus seen by the UART: core address/data/strobes in, load data out.
interface uart_tx_mmio_if;
  logic [31:0] DIR_DMEM;
  logic [31:0] DATA_WRITE_DMEM;
  logic        WRITE;
  logic        READ;
  logic [31:0] DATA_READ_UART;

  modport master (
    output DIR_DMEM,
    output DATA_WRITE_DMEM,
    output WRITE,
    output READ,
    input  DATA_READ_UART
  );

  modport slave (
    input  DIR_DMEM,
    input  DATA_WRITE_DMEM,
    input  WRITE,
    input  READ,
    output DATA_READ_UART
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window on the data bus, transmit FIFO,
// bit-timing FSM. Loads are answered combinationally; TX and IRQ are registered.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DIV_DEFAULT = 16'd433
) (
  input  logic          CLK,
  input  logic          RESET,
  uart_tx_mmio_if.slave bus,
  output logic          TX,
  output logic          IRQ
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   reload_q, reload_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   divisor_q, divisor_d;
  logic          en_q, en_d;
  logic          irq_en_q, irq_en_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;

  logic       sel;
  logic [1:0] off;
  logic       full, empty, pop, push_req, push_acc, bit_done;
  logic [31:0] status;
  logic       unused_bits;

  assign sel         = (bus.DIR_DMEM[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.DIR_DMEM[3:2];
  assign full        = (count_q == CntW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign bit_done    = (timer_q == reload_q);
  assign push_req    = bus.WRITE & sel & (off == 2'd0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_acc    = push_req & (~full | pop);
  assign unused_bits = ^{bus.DIR_DMEM[1:0], bus.DATA_WRITE_DMEM[31:16]};

  always_comb begin
    status      = '0;
    status[0]   = (state_q != StIdle);
    status[1]   = full;
    status[2]   = empty;
    status[3]   = overrun_q;
    status[8:4] = 5'(count_q);
  end

  // Bit-timing FSM: each of start/data/stop lasts reload_q+1 clocks; pops the FIFO head.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    timer_d   = timer_q;
    reload_d  = reload_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_q && !empty) begin
          pop      = 1'b1;
          shift_d  = fifo_q[rd_ptr_q];
          reload_d = divisor_q;
          timer_d  = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d   = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          timer_d = '0;
          if (en_q && !empty) begin
            pop      = 1'b1;
            shift_d  = fifo_q[rd_ptr_q];
            reload_d = divisor_q;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointers/count, overrun flag and the writable config registers.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CntW'(push_acc) - CntW'(pop);
    overrun_d = overrun_q;
    divisor_d = divisor_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    if (push_acc) begin
      fifo_d[wr_ptr_q] = bus.DATA_WRITE_DMEM[7:0];
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_req && !push_acc) overrun_d = 1'b1;
    if (bus.WRITE && sel) begin
      unique case (off)
        2'd1:    if (bus.DATA_WRITE_DMEM[3]) overrun_d = 1'b0;
        2'd2:    divisor_d = bus.DATA_WRITE_DMEM[15:0];
        2'd3: begin
          en_d     = bus.DATA_WRITE_DMEM[0];
          irq_en_d = bus.DATA_WRITE_DMEM[1];
        end
        default: ;
      endcase
    end
  end

  // Registered line and interrupt; TX lags the FSM state by one clock uniformly.
  always_comb begin
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = irq_en_d & (count_d == '0) & (state_d == StIdle);
  end

  // Combinational load data, zero when not selected so it can be OR-merged with RAM.
  always_comb begin
    bus.DATA_READ_UART = '0;
    if (bus.READ && sel) begin
      unique case (off)
        2'd1:    bus.DATA_READ_UART = status;
        2'd2:    bus.DATA_READ_UART = {16'd0, divisor_q};
        2'd3:    bus.DATA_READ_UART = {30'd0, irq_en_q, en_q};
        default: bus.DATA_READ_UART = '0;
      endcase
    end
  end

  // Control/status state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      timer_q   <= '0;
      reload_q  <= DIV_DEFAULT;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      divisor_q <= DIV_DEFAULT;
      en_q      <= 1'b1;
      irq_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      timer_q   <= timer_d;
      reload_q  <= reload_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      divisor_q <= divisor_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    fifo_q <= fifo_d;
  end

  assign TX  = tx_q;
  assign IRQ = irq_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a line monitor decodes TX frames against a byte scoreboard,
// and per-scenario tasks check registers and cycle-exact timing.
module tb_uart_tx_mmio;
  localparam logic [31:0] ATx   = 32'h0001_0000;
  localparam logic [31:0] ASt   = 32'h0001_0004;
  localparam logic [31:0] ADiv  = 32'h0001_0008;
  localparam logic [31:0] ACtrl = 32'h0001_000C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, irq;
  uart_tx_mmio_if bus();

  uart_tx_mmio dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .TX    (tx),
    .IRQ   (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_count = 0;
  int mon_period = 434;
  logic mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int watch_c0;
  logic tx_s[64];
  logic irq_s[64];
  logic [31:0] st_s[64];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- line monitor / scoreboard ----------------
  int m_p;
  logic [7:0] m_b, m_e;
  logic m_ok, m_ab;

  task automatic mon_wait(input int n, output logic ab);
    ab = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        m_p = mon_period;
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        m_ok = 1'b1;
        m_b = '0;
        mon_wait(m_p / 2, m_ab);
        if (!m_ab && tx !== 1'b0) m_ok = 1'b0;
        for (int i = 0; i < 8 && !m_ab; i++) begin
          mon_wait(m_p, m_ab);
          m_b[i] = tx;
        end
        if (!m_ab) begin
          mon_wait(m_p, m_ab);
          if (tx !== 1'b1) m_ok = 1'b0;
        end
        if (!m_ab) begin
          total++;
          rx_count++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rx_frame: got byte %02h, required no frame", m_b);
          end else begin
            m_e = exp_q.pop_front();
            if (!m_ok || m_b !== m_e) begin
              bad++;
              $display("FAIL rx_frame: got %02h framing_ok=%0b, required %02h framing_ok=1",
                       m_b, m_ok, m_e);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.DIR_DMEM = a;
    bus.DATA_WRITE_DMEM = d;
    bus.WRITE = 1'b1;
    @(negedge clk);
    bus.WRITE = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.DIR_DMEM = a;
    bus.READ = 1'b1;
    #1 d = bus.DATA_READ_UART;
    bus.READ = 1'b0;
  endtask

  // Store one byte, then record TX/IRQ/STATUS at the n negedges following the store edge.
  task automatic store_watch(input logic [7:0] b, input int n);
    @(negedge clk);
    bus.DIR_DMEM = ATx;
    bus.DATA_WRITE_DMEM = {24'd0, b};
    bus.WRITE = 1'b1;
    @(negedge clk);
    bus.WRITE = 1'b0;
    bus.DIR_DMEM = ASt;
    bus.READ = 1'b1;
    watch_c0 = cyc;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tx_s[k] = tx;
      irq_s[k] = irq;
      st_s[k] = bus.DATA_READ_UART;
    end
    bus.READ = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || mon_busy) begin
      bad++;
      $display("FAIL drain: pending=%0d busy=%0b after %0d cycles, required pending=0",
               exp_q.size(), mon_busy, n);
    end
  endtask

  function automatic logic exp_tx(input int k, input int p, input logic [7:0] b);
    if (k < 2) return 1'b1;
    if (k < 2 + p) return 1'b0;
    if (k < 2 + 9 * p) return b[(k - 2 - p) / p];
    return 1'b1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b required 0", irq); end
    bus_read(ASt, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_status: got %h required 4", d); end
    bus_read(ADiv, d);
    total++; if (d !== 32'd433) begin bad++; $display("FAIL reset_div: got %0d required 433", d); end
    bus_read(ACtrl, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_ctrl: got %h required 1", d); end
    bus_read(ATx, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h required 0", d); end
    bus.DIR_DMEM = ASt;
    #1;
    total++;
    if (bus.DATA_READ_UART !== 32'h0) begin
      bad++; $display("FAIL noread_zero: got %h required 0", bus.DATA_READ_UART);
    end
  endtask

  task automatic test_single();
    int errs;
    int first;
    bus_write(ADiv, 32'd3);
    mon_period = 4;
    start_q.delete();
    exp_q.push_back(8'hA5);
    store_watch(8'hA5, 43);
    errs = 0;
    first = -1;
    for (int k = 0; k < 43; k++) begin
      if (tx_s[k] !== exp_tx(k, 4, 8'hA5)) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL single_wave: %0d wrong samples, first at cycle %0d", errs, first);
    end
    total++;
    if (st_s[0] !== 32'h10) begin bad++; $display("FAIL single_st0: got %h required 10", st_s[0]); end
    total++;
    if (st_s[40][0] !== 1'b1 || st_s[41][0] !== 1'b0) begin
      bad++; $display("FAIL single_busy: got %b%b required 10", st_s[40][0], st_s[41][0]);
    end
    wait_drain(100);
    total++;
    if (start_q.size() < 1 || start_q[0] !== watch_c0 + 2) begin
      bad++; $display("FAIL single_start: got %0d starts, required start at %0d",
                      start_q.size(), watch_c0 + 2);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [31:0] d;
    bus_write(ADiv, 32'd1);
    mon_period = 2;
    start_q.delete();
    for (int i = 1; i <= 3; i++) exp_q.push_back(8'(i));
    @(negedge clk);
    bus.DIR_DMEM = ATx;
    bus.WRITE = 1'b1;
    bus.DATA_WRITE_DMEM = 32'h01;
    @(negedge clk);
    c0 = cyc;
    bus.DATA_WRITE_DMEM = 32'h02;
    @(negedge clk);
    bus.DATA_WRITE_DMEM = 32'h03;
    @(negedge clk);
    bus.WRITE = 1'b0;
    bus.DIR_DMEM = ASt;
    bus.READ = 1'b1;
    #1 d = bus.DATA_READ_UART;
    bus.READ = 1'b0;
    total++;
    if (d[8:4] !== 5'd2) begin bad++; $display("FAIL b2b_count: got %0d required 2", d[8:4]); end
    wait_drain(200);
    total++;
    if (start_q.size() != 3 || start_q[0] != c0 + 2 || start_q[1] != c0 + 22
        || start_q[2] != c0 + 42) begin
      bad++;
      $display("FAIL b2b_starts: got %0d starts, required 3 at offsets 2/22/42", start_q.size());
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    int r0;
    bus_write(ACtrl, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'h10 + 8'(i));
      bus_write(ATx, 32'h10 + i);
    end
    bus_read(ASt, d);
    total++; if (d !== 32'h8A) begin bad++; $display("FAIL ovr_status: got %h required 8a", d); end
    bus_write(ASt, 32'h8);
    bus_read(ASt, d);
    total++; if (d !== 32'h82) begin bad++; $display("FAIL ovr_clear: got %h required 82", d); end
    r0 = rx_count;
    bus_write(ACtrl, 32'h1);
    wait_drain(400);
    repeat (50) @(negedge clk);
    total++;
    if (rx_count - r0 != 8) begin
      bad++; $display("FAIL ovr_frames: got %0d required 8", rx_count - r0);
    end
    bus_read(ASt, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL ovr_final: got %h required 4", d); end
  endtask

  task automatic test_irq_window();
    logic [31:0] d;
    int r0;
    bus_write(ADiv, 32'd3);
    mon_period = 4;
    bus_write(ACtrl, 32'h3);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle: got %b required 1", irq); end
    exp_q.push_back(8'h3C);
    store_watch(8'h3C, 42);
    total++;
    if (irq_s[0] !== 1'b0 || irq_s[40] !== 1'b0 || irq_s[41] !== 1'b1) begin
      bad++; $display("FAIL irq_edge: got %b%b%b required 001", irq_s[0], irq_s[40], irq_s[41]);
    end
    wait_drain(100);
    r0 = rx_count;
    bus_write(32'h0001_0010, 32'hFFFF_FFFF);
    bus_read(ASt, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL win_status: got %h required 4", d); end
    bus_read(ADiv, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL win_div: got %h required 3", d); end
    bus_read(ACtrl, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL win_ctrl: got %h required 3", d); end
    bus_read(32'h0001_0010, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL win_read: got %h required 0", d); end
    repeat (60) @(negedge clk);
    total++;
    if (rx_count != r0) begin bad++; $display("FAIL win_frames: got %0d required 0", rx_count - r0); end
    bus_write(ACtrl, 32'h1);
  endtask

  task automatic test_midframe();
    logic [31:0] d;
    int r0;
    start_q.delete();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    bus_write(ATx, 32'h5A);
    bus_write(ATx, 32'hC3);
    repeat (8) @(negedge clk);
    bus_write(ADiv, 32'd7);
    mon_period = 8;
    wait_drain(400);
    total++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 40) begin
      bad++; $display("FAIL mid_div: got %0d starts, required 2 spaced 40", start_q.size());
    end
    // Reset in the middle of a data phase of an all-zero byte, with one more queued.
    r0 = rx_count;
    bus_write(ATx, 32'h00);
    bus_write(ATx, 32'h00);
    repeat (20) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre: got %b required 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_rst_tx: got %b required 1", tx); end
    rst = 1'b0;
    bus_read(ASt, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL mid_rst_st: got %h required 4", d); end
    repeat (200) @(negedge clk);
    total++;
    if (rx_count != r0) begin bad++; $display("FAIL mid_rst_frames: got %0d required 0", rx_count - r0); end
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    bus.DIR_DMEM = '0;
    bus.DATA_WRITE_DMEM = '0;
    bus.WRITE = 1'b0;
    bus.READ = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_irq_window();
    test_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data-memory bus, downstream of the single-cycle core next to the data RAM. Stores whose address falls in its 16-byte window push bytes into a transmit FIFO, or write the configuration registers. A bit-timing state machine serialises the FIFO contents as 8N1 frames on `TX`. Loads in the window return status and configuration data combinationally, within the core's single cycle.

## Interface
- `BASE_ADDR`, default 32'h0001_0000: window base; bits [3:0] must be 0.
- `FIFO_DEPTH`, default 8: transmit FIFO entries; power of two, 2..16.
- `DIV_DEFAULT`, default 16'd433: reset value of DIVISOR; bit period is DIVISOR+1 clocks.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: reset is synchronous and active-high.
- `DIR_DMEM` input 32: data-bus byte address from the core.
- `DATA_WRITE_DMEM` input 32: store data from the core.
- `WRITE` input 1: store strobe; one store per cycle it is high.
- `READ` input 1: load strobe.
- `DATA_READ_UART` output 32: load data; 0 when not selected, so it can be OR-merged with RAM data.
- `TX` output 1: serial line, idle high.
- `IRQ` output 1: level interrupt, registered.

## Operation
- Select: `SEL = (DIR_DMEM[31:4] == BASE_ADDR[31:4])`. Register offset = `DIR_DMEM[3:2]`. `DIR_DMEM[1:0]` is ignored. Accesses outside the window have no effect.
- Offset 0, TXDATA:
  - Write pushes `DATA_WRITE_DMEM[7:0]`.
  - Read returns 0.
- Offset 1, STATUS (read):
  - bit0 BUSY: FSM not IDLE.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVERRUN: sticky.
  - bits[8:4]: FIFO count.
  - Other bits 0.
  - Write with `DATA_WRITE_DMEM[3]`=1 clears OVERRUN. Other bits are ignored.
- Offset 2, DIVISOR: R/W; bits [15:0] used; upper bits read 0.
- Offset 3, CTRL: R/W.
  - bit0 EN, reset 1.
  - bit1 IRQ_EN, reset 0.
- FIFO push rules:
  - A push is accepted if not FULL, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and OVERRUN is set.
- Read data is combinational from current register state: `READ`&`SEL` muxes the register, else 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if EN and FIFO not empty, pop the head into the shift register, latch DIVISOR into the bit timer reload, go to START.
  - START: `TX`=0 for DIVISOR+1 clocks, then go to DATA with bit index 0.
  - DATA: `TX`=shift[0] (LSB first), 8 bits each DIVISOR+1 clocks, then go to STOP.
  - STOP: `TX`=1 for DIVISOR+1 clocks. Then, if EN and FIFO not empty, pop and go directly to START (back-to-back frames); else go to IDLE.
- `TX` is registered and driven from the FSM state and shift register.
- A DIVISOR write mid-frame takes effect from the next frame.
- Clearing EN mid-frame lets the current frame complete; no further pops occur.
- `IRQ` <= IRQ_EN & EMPTY & (state==IDLE), evaluated on next-state values.

## Timing
- Reset values:
  - `TX`=1, `IRQ`=0, `DATA_READ_UART`=0 when unselected.
  - FIFO empty, OVERRUN=0.
  - DIVISOR=DIV_DEFAULT, CTRL=32'h1, FSM in IDLE.
- `RESET` mid-frame aborts the frame; `TX` is 1 after that edge.
- A store at edge N updates count/registers at edge N.
- If IDLE and EN: the pop happens at edge N+1 and `TX` falls after edge N+2. Start bit begins 2 cycles after the store edge.
- Frame length is exactly 10×(DIVISOR+1) clocks. Back-to-back frames have no idle gap.
- Simultaneous push and pop when full: both occur, count unchanged, no OVERRUN.
- Simultaneous OVERRUN set (push dropped) and clear (STATUS write) cannot occur, since one store per cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

## Test plan
- Reset: assert `RESET` 2 cycles.
  - `TX`=1, `IRQ`=0.
  - Load 0x10004 returns 32'h0000_0004.
  - Load 0x10008 returns 433.
  - Load 0x1000C returns 1.
- Single frame: write DIVISOR=3, store 0xA5 to 0x10000.
  - `TX` low 2 cycles after the store, for 4 clocks.
  - Then bits 1,0,1,0,0,1,0,1, 4 clocks each.
  - Then high 4 clocks; BUSY cleared after 40 clocks.
- Back-to-back: DIVISOR=1, store 0x01, 0x02, 0x03 on consecutive cycles.
  - Three contiguous 20-clock frames with no gap.
  - Count reads 2 one cycle after the first pop.
- Overrun: EN=0, push 9 bytes into depth 8.
  - STATUS = FULL|OVERRUN|count 8 = 32'h8A.
  - Write 0x8 to STATUS: reads 32'h82.
  - Set EN=1: exactly 8 frames are sent.
- IRQ and window: IRQ_EN=1, send one byte.
  - `IRQ` rises the cycle after the STOP bit ends.
  - Store to 0x10010 leaves all registers unchanged; load there returns 0.
- Mid-frame changes:
  - Change DIVISOR from 3 to 7 during the DATA state: current frame keeps 4-clock bits; next frame uses 8.
  - Assert `RESET` mid-DATA: `TX`=1 next cycle, FIFO empty.
